// File: rtl/fft_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : fft_input_loader
// Description : Streaming front end of the FFT core. Scatters accepted samples
//               across the four RAM banks and kicks the core per full frame.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_input_loader #(
    parameter int ADDR_W = 9
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iVALID,
    input  logic [15:0]       iDATA,
    input  logic              iLAST,
    output logic              oREADY,
    input  logic              iFFT_RDY,
    output logic [15:0]       oDATA,
    output logic [ADDR_W-1:0] oADDR_WR_0,
    output logic [ADDR_W-1:0] oADDR_WR_1,
    output logic [ADDR_W-1:0] oADDR_WR_2,
    output logic [ADDR_W-1:0] oADDR_WR_3,
    output logic              oWE_0,
    output logic              oWE_1,
    output logic              oWE_2,
    output logic              oWE_3,
    output logic              oSTART,
    output logic              oBUSY,
    output logic              oERR
);

    localparam int                 c_CNT_W    = ADDR_W + 2;
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = '1;
    localparam logic [1:0]         c_S_LOAD   = 2'd0;
    localparam logic [1:0]         c_S_KICK   = 2'd1;
    localparam logic [1:0]         c_S_WAIT   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_err_nxt;
    logic               r_run;
    logic               r_rdy_q1;
    logic               r_rdy_q2;
    logic               w_rdy_rise;
    logic               w_accept;
    logic [15:0]        r_data;
    logic [3:0]         r_we;
    logic [ADDR_W-1:0]  r_addr [4];
    logic               r_start;
    logic               r_err;

    // r_run keeps READY low until the first edge after reset is released
    assign oREADY     = r_run && (r_state == c_S_LOAD);
    assign oBUSY      = (r_state == c_S_WAIT);
    assign w_accept   = iVALID && oREADY;
    assign w_rdy_rise = r_rdy_q1 && !r_rdy_q2;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_state  <= c_S_LOAD;
            r_cnt    <= '0;
            r_run    <= 1'b0;
            r_rdy_q1 <= 1'b0;
            r_rdy_q2 <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_run    <= 1'b1;
            r_rdy_q1 <= iFFT_RDY;
            r_rdy_q2 <= r_rdy_q1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        case (r_state)
            c_S_LOAD: begin
                if (w_accept) begin
                    if (r_cnt == c_LAST_IDX) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_S_KICK;
                        w_err_nxt   = !iLAST;
                    end else if (iLAST) begin
                        // short frame: abandon it, next frame overwrites banks
                        w_cnt_nxt = '0;
                        w_err_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            c_S_KICK: w_state_nxt = c_S_WAIT;
            c_S_WAIT: begin
                // only a fresh rise counts; a level held from entry is ignored
                if (w_rdy_rise) begin
                    w_state_nxt = c_S_LOAD;
                end
            end
            default: w_state_nxt = c_S_LOAD;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_data  <= '0;
            r_we    <= '0;
            r_start <= 1'b0;
            r_err   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_addr[k] <= '0;
            end
        end else begin
            r_start <= (r_state == c_S_KICK);
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_data <= iDATA;
            end
            for (int k = 0; k < 4; k++) begin
                r_we[k] <= w_accept && (r_cnt[1:0] == 2'(k));
                if (w_accept && (r_cnt[1:0] == 2'(k))) begin
                    r_addr[k] <= r_cnt[c_CNT_W-1:2];
                end
            end
        end
    end

    assign oDATA      = r_data;
    assign oWE_0      = r_we[0];
    assign oWE_1      = r_we[1];
    assign oWE_2      = r_we[2];
    assign oWE_3      = r_we[3];
    assign oADDR_WR_0 = r_addr[0];
    assign oADDR_WR_1 = r_addr[1];
    assign oADDR_WR_2 = r_addr[2];
    assign oADDR_WR_3 = r_addr[3];
    assign oSTART     = r_start;
    assign oERR       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_input_loader
// Description : Directed bench for fft_input_loader at N=2048 and N=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_input_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // N=16 instance
    logic        v, l, rdy;
    logic [15:0] d;
    logic        ready, start, busy, err, we0, we1, we2, we3;
    logic [15:0] od;
    logic [1:0]  a0, a1, a2, a3;

    // N=2048 instance
    logic        bv, bl, brdy;
    logic [15:0] bd;
    logic        bready, bstart, bbusy, berr, bwe0, bwe1, bwe2, bwe3;
    logic [15:0] bod;
    logic [8:0]  ba0, ba1, ba2, ba3;
    logic [3:0]  bwe;
    assign bwe = {bwe3, bwe2, bwe1, bwe0};

    int errors   = 0;
    int checks   = 0;
    int bad      = 0;
    int s_starts = 0;

    fft_input_loader #(.ADDR_W(2)) dut (
        .iCLK(clk), .iRESET(rst), .iVALID(v), .iDATA(d), .iLAST(l), .oREADY(ready),
        .iFFT_RDY(rdy), .oDATA(od),
        .oADDR_WR_0(a0), .oADDR_WR_1(a1), .oADDR_WR_2(a2), .oADDR_WR_3(a3),
        .oWE_0(we0), .oWE_1(we1), .oWE_2(we2), .oWE_3(we3),
        .oSTART(start), .oBUSY(busy), .oERR(err)
    );

    fft_input_loader big (
        .iCLK(clk), .iRESET(rst), .iVALID(bv), .iDATA(bd), .iLAST(bl), .oREADY(bready),
        .iFFT_RDY(brdy), .oDATA(bod),
        .oADDR_WR_0(ba0), .oADDR_WR_1(ba1), .oADDR_WR_2(ba2), .oADDR_WR_3(ba3),
        .oWE_0(bwe0), .oWE_1(bwe1), .oWE_2(bwe2), .oWE_3(bwe3),
        .oSTART(bstart), .oBUSY(bbusy), .oERR(berr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] we_s();
        return {we3, we2, we1, we0};
    endfunction

    function automatic logic [1:0] addr_s(input int b);
        case (b)
            0:       return a0;
            1:       return a1;
            2:       return a2;
            default: return a3;
        endcase
    endfunction

    function automatic logic [8:0] baddr_s(input int b);
        case (b)
            0:       return ba0;
            1:       return ba1;
            2:       return ba2;
            default: return ba3;
        endcase
    endfunction

    function automatic logic [31:0] outs_s();
        return {ready, we_s(), start, busy, err, od, a3, a2, a1, a0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one sample that must be accepted; frame index idx sets bank/address
    task automatic push(input int idx, input logic [15:0] dat, input logic lst);
        v = 1'b1; d = dat; l = lst;
        if (ready !== 1'b1) bad++;
        tick();
        v = 1'b0; l = 1'b0;
        if (we_s() !== 4'(1 << (idx % 4))) bad++;
        if (addr_s(idx % 4) !== 2'(idx / 4)) bad++;
        if (od !== dat) bad++;
        s_starts += int'(start);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, guard, starts, errs, hold_bad;
        logic r_before, v_before;

        rst = 1'b1; v = 1'b0; l = 1'b0; d = '0; rdy = 1'b0;
        bv = 1'b0; bl = 1'b0; bd = '0; brdy = 1'b0;
        #1;
        chk("reset_outputs", outs_s(), 32'h0);
        chk("reset_big_ctl", {bready, bwe, bstart, bbusy, berr}, 32'h0);
        chk("reset_big_data", {bod, ba0}, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("ready_before_first_edge", ready, 1'b0);
        tick();
        chk("ready_after_first_edge", ready, 1'b1);

        // ---------------- full N=2048 frame ----------------
        starts = 0; errs = 0;
        for (int i = 0; i < 2048; i++) begin
            bv = 1'b1; bd = 16'(i); bl = (i == 2047);
            if (bready !== 1'b1) bad++;
            tick();
            if (bwe !== 4'(1 << (i % 4))) bad++;
            if (bod !== 16'(i)) bad++;
            if (baddr_s(i % 4) !== 9'(i / 4)) bad++;
            starts += int'(bstart);
            errs   += int'(berr);
            if (i == 5) begin
                chk("big_s5_we", bwe, 4'b0010);
                chk("big_s5_addr", ba1, 9'd1);
                chk("big_s5_data", bod, 16'd5);
            end
            if (i == 2047) begin
                chk("big_s2047_we", bwe, 4'b1000);
                chk("big_s2047_addr", ba3, 9'd511);
                chk("big_kick_ready", bready, 1'b0);
            end
        end
        bv = 1'b0; bl = 1'b0;
        tick();
        chk("big_start_busy", {bstart, bbusy}, 2'b11);
        chk("big_no_write_after_last", bwe, 4'b0000);
        starts += int'(bstart); errs += int'(berr);
        repeat (3) begin
            tick();
            starts += int'(bstart); errs += int'(berr);
        end
        chk("big_start_count", starts, 1);
        chk("big_err_never", errs, 0);
        chk("big_wait_busy", {bbusy, bready}, 2'b10);

        // ---------------- N=16 random duty cycle ----------------
        rdy = 1'b1;  // already high when WAIT is entered
        n = 0; guard = 0;
        while (n < 16 && guard < 500) begin
            v = ($urandom_range(0, 2) != 0);
            d = 16'(16'h100 + n);
            l = (n == 15);
            r_before = ready; v_before = v;
            tick();
            guard++;
            if (v_before && r_before) begin
                if (we_s() !== 4'(1 << (n % 4))) bad++;
                if (addr_s(n % 4) !== 2'(n / 4)) bad++;
                if (od !== 16'(16'h100 + n)) bad++;
                n++;
            end else if (we_s() !== 4'b0000) begin
                bad++;
            end
            if (err !== 1'b0) bad++;
        end
        v = 1'b0; l = 1'b0;
        chk("duty_samples_accepted", n, 16);
        chk("duty_kick_ready", ready, 1'b0);
        tick();
        chk("duty_start", {start, busy}, 2'b11);

        // ---------------- WAIT with iFFT_RDY high from entry ----------------
        hold_bad = 0;
        v = 1'b1; d = 16'hBEEF;
        repeat (6) begin
            tick();
            if (ready !== 1'b0 || we_s() !== 4'b0000 || busy !== 1'b1 || start !== 1'b0) hold_bad++;
        end
        chk("wait_holds_with_rdy_level", hold_bad, 0);
        rdy = 1'b0;
        repeat (3) tick();
        chk("wait_after_drop", {busy, ready}, 2'b10);
        rdy = 1'b1;
        tick();
        chk("rise_edge1_ready", ready, 1'b0);
        tick();
        v = 1'b0;
        chk("rise_edge2_ready_busy", {ready, busy}, 2'b10);

        // ---------------- early iLAST on sample 7 ----------------
        s_starts = 0;
        for (int i = 0; i < 7; i++) push(i, 16'(16'h200 + i), 1'b0);
        push(7, 16'h0207, 1'b1);
        chk("early_last_err", err, 1'b1);
        tick();
        s_starts += int'(start);
        chk("early_last_err_one_cycle", err, 1'b0);
        chk("early_last_stays_load", {ready, busy}, 2'b10);
        push(0, 16'h0AAA, 1'b0);
        chk("after_abort_bank0", we_s(), 4'b0001);
        chk("after_abort_addr0", a0, 2'd0);

        // ---------------- omit iLAST on sample 15 ----------------
        for (int i = 1; i < 15; i++) push(i, 16'(16'h300 + i), 1'b0);
        chk("early_last_no_start", s_starts, 0);
        push(15, 16'h030F, 1'b0);
        chk("omit_last_err", err, 1'b1);
        tick();
        chk("omit_last_start", {start, err}, 2'b10);
        rdy = 1'b0;
        repeat (2) tick();
        rdy = 1'b1;
        repeat (2) tick();
        chk("omit_last_back_to_load", ready, 1'b1);

        // ---------------- reset mid-frame ----------------
        for (int i = 0; i < 10; i++) push(i, 16'(16'h400 + i), 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midframe_reset_outputs", outs_s(), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        chk("midframe_release_ready", ready, 1'b1);
        push(0, 16'h0555, 1'b0);
        chk("midframe_first_bank0", {we_s(), a0}, {4'b0001, 2'd0});

        // ---------------- reset mid-WAIT ----------------
        for (int i = 1; i < 16; i++) push(i, 16'(16'h500 + i), (i == 15));
        tick();
        tick();
        chk("midwait_in_wait", {busy, ready}, 2'b10);
        #2 rst = 1'b1;
        #1;
        chk("midwait_reset_outputs", outs_s(), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        chk("midwait_release_ready", ready, 1'b1);
        push(0, 16'h0666, 1'b0);
        chk("midwait_first_bank0", {we_s(), a0, od}, {4'b0001, 2'd0, 16'h0666});

        chk("write_sequence_errors", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_input_loader.md
# fft_input_loader

Streaming front end of the FFT core. It accepts 16-bit real samples over a valid/ready handshake and scatters them across the four RAM banks through the core's external write ports (`iDATA`, `iADDR_WR_0..3`, `iWE_0..3`). When a full frame is stored it pulses the core's `iSTART`, then holds off new input until the core reports completion on `oRDY`.

## Interface
Parameters:
- `ADDR_W`, default 9: bank address width. Frame length N = 4·2^ADDR_W, which is 2048 at the default.

Ports (name, direction, width, meaning):
- `iCLK` in 1: single clock, rising edge.
- `iRESET` in 1: asynchronous, active-high reset. This is already decided.
- `iVALID` in 1: upstream sample valid.
- `iDATA` in 16: signed sample.
- `iLAST` in 1: upstream marks the final sample of a frame.
- `oREADY` out 1: block accepts a sample when `iVALID && oREADY`.
- `iFFT_RDY` in 1: connects to the core's `oRDY`.
- `oDATA` out 16: connects to the core's `iDATA`.
- `oADDR_WR_0..3` out ADDR_W each: connect to the core's `iADDR_WR_0..3`.
- `oWE_0..3` out 1 each: connect to the core's `iWE_0..3`.
- `oSTART` out 1: one-cycle pulse to the core's `iSTART`.
- `oBUSY` out 1: high from frame-complete until `iFFT_RDY` is seen.
- `oERR` out 1: one-cycle pulse when `iLAST` framing does not match N.

## Operation
- Sample counter `cnt` is log2(N) bits wide. For a sample accepted with count n:
  - bank = n[1:0]
  - address = n[log2(N)-1:2]
  - The write goes to bank `n[1:0]` only. The other three `oWE_k` stay low.
- State register has three states: LOAD, KICK, WAIT.
- Reset places the block in LOAD with `cnt=0`.
- `oREADY` = (state==LOAD). It is decoded from the state register only, so there is no combinational path from `iVALID`.
- LOAD:
  - Each accept increments `cnt`.
  - Accept with `cnt==N-1` sets `cnt` to 0 and moves to KICK.
  - If `iLAST` is not 1 on that sample, `oERR` pulses but the frame still completes.
  - Accept with `iLAST=1` and `cnt!=N-1`: `oERR` pulses, `cnt` returns to 0, and the block stays in LOAD. The partial frame is abandoned and no `oSTART` is issued; the data already written to the banks is simply overwritten by the next frame.
- KICK: lasts one cycle, then moves to WAIT. `oSTART` is registered and pulses in the cycle after KICK (see Timing).
- WAIT:
  - `oBUSY=1`, no accepts.
  - A rising edge of `iFFT_RDY` returns the block to LOAD. Rising edge means the value registered in the previous cycle was 0 and the current value is 1.
  - An `iFFT_RDY` level that is already high on entry to WAIT is ignored until it has dropped and risen again.
- Reset mid-frame or mid-WAIT abandons all progress.
- Downstream reads through `iADDR_RD_*` are outside this block's scope.

## Timing
- Reset values of all outputs are 0: `oDATA`, `oADDR_WR_*`, `oWE_*`, `oSTART`, `oBUSY`, `oERR`. `oREADY` becomes 1 on the first clock edge after reset is released; it is 1 combinationally as soon as the state is LOAD.
- Write latency is 1 cycle. A sample accepted at edge t appears as `oDATA`, `oADDR_WR_k`, `oWE_k=1` during the cycle after edge t and is written by the core at edge t+1.
- Full throughput: one sample per cycle while `iVALID` stays high in LOAD.
- Sequence for the last sample of a frame, accepted at edge t:
  - Last write presented in cycle t..t+1.
  - State is KICK in the same cycle, so `oREADY=0`.
  - `oSTART=1` for exactly the cycle between edges t+1 and t+2, so the start follows the final write.
  - `oBUSY` rises at t+1.
- `oERR` is registered and pulses in the cycle after the offending accept.
- `iFFT_RDY` rising edge detected at edge r: state is LOAD and `oBUSY=0` from edge r+1; the first new accept is possible at edge r+2.
- `iVALID` while `oREADY=0`: the sample is not consumed. Upstream holds `iDATA` and `iLAST` stable.

## Test plan
- Reset, then stream N=2048 samples with value = index and `iLAST` on index 2047:
  - Sample 5 appears with bank 1, addr 1, `oDATA=5`.
  - Sample 2047 appears with bank 3, addr 511.
  - Exactly one `oSTART` pulse, one cycle after the last `oWE_3`.
  - `oERR` never asserts.
- With ADDR_W=2 (N=16), drive `iVALID` with a random duty cycle:
  - Every sample is written exactly once to (n%4, n/4).
  - No write occurs while `oREADY=0`.
- In WAIT, hold `iFFT_RDY=1` from entry: the block stays in WAIT. Drop it and raise it again: `oREADY=1` two edges after the rise.
- Assert `iLAST` on sample 7 with N=16:
  - `oERR` pulses one cycle later.
  - No `oSTART`.
  - The next accepted sample writes to bank 0, addr 0.
- Omit `iLAST` on sample N-1: `oERR` pulses and `oSTART` still pulses.
- Assert `iRESET` asynchronously mid-frame at sample 9 and mid-WAIT:
  - All outputs go to 0 immediately.
  - After release, the first sample goes to bank 0, addr 0.
